// File: rtl/xilinx_distram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_distram_pkg
// Brief    : Shared state encoding and depth helper for the distram delay line.
// Revision : 1.0 - initial release
// ============================================================================
package xilinx_distram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dly_state_e;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xilinx_sp_distram.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_sp_distram
// Brief    : Single-port distributed RAM, asynchronous read, synchronous write.
// Revision : 1.0 - initial release
// ============================================================================
module xilinx_sp_distram
    import xilinx_distram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] o
);

    localparam int unsigned c_depth = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge wclk) begin
        if (we) begin
            r_mem[a] <= d;
        end
    end

    // Read is combinational, so a step sees the old word before its own write.
    assign o = r_mem[a];

endmodule
`default_nettype wire

// File: rtl/xilinx_distram_delay.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_distram_delay
// Brief    : CE-gated programmable delay line over one single-port distram,
//            with a zeroing sweep after reset or flush.
// Revision : 1.0 - initial release
// ============================================================================
module xilinx_distram_delay
    import xilinx_distram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    output logic                  busy
);

    localparam int unsigned           c_depth = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(c_depth - 1);

    dly_state_e              r_state;
    dly_state_e              w_state_next;
    logic [ADDR_WIDTH-1:0]   r_sweep;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   r_len_q;
    logic [ADDR_WIDTH:0]     r_fill;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_dvalid;

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [ADDR_WIDTH:0]     w_period;
    logic [ADDR_WIDTH:0]     w_fill_next;
    logic                    w_init;

    assign w_init   = (r_state == ST_INIT);
    assign w_period = {1'b0, r_len_q} + (ADDR_WIDTH+1)'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (!flush && (r_sweep == c_last)) w_state_next = ST_RUN;
            ST_RUN:  if (flush) w_state_next = ST_INIT;
            default: w_state_next = ST_INIT;
        endcase
    end

    always_comb begin
        w_addr      = w_init ? r_sweep : r_ptr;
        w_wdata     = w_init ? '0 : din;
        w_we        = w_init | (ce & ~flush);
        // Saturate at the current period so dvalid stays up across steps.
        w_fill_next = (r_fill >= w_period) ? w_period : r_fill + (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep  <= '0;
            r_ptr    <= '0;
            r_len_q  <= '0;
            r_fill   <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else if (w_init) begin
            r_sweep <= flush ? '0 : r_sweep + ADDR_WIDTH'(1);
            if (!flush && (r_sweep == c_last)) begin
                r_ptr   <= '0;
                r_len_q <= len;
            end
        end else if (flush) begin
            r_sweep  <= '0;
            r_ptr    <= '0;
            r_fill   <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else if (ce) begin
            r_dout   <= w_rdata;
            r_dvalid <= (r_fill >= w_period);
            r_fill   <= w_fill_next;
            // New period length only takes effect at a wrap.
            if (r_ptr == r_len_q) begin
                r_ptr   <= '0;
                r_len_q <= len;
            end else begin
                r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    xilinx_sp_distram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .wclk (clk),
        .we   (w_we),
        .a    (w_addr),
        .d    (w_wdata),
        .o    (w_rdata)
    );

    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign busy   = w_init;

endmodule
`default_nettype wire

// File: tb/tb_xilinx_distram_delay.sv
`default_nettype none
// ============================================================================
// Module   : tb_xilinx_distram_delay
// Brief    : Directed self-checking bench for the distram delay line (D=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xilinx_distram_delay;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] len = 4'd0;
    logic       flush = 1'b0;
    logic [7:0] dout;
    logic       dvalid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    xilinx_distram_delay #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .din    (din),
        .len    (len),
        .flush  (flush),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] l);
        int n;
        rst_n = 1'b0;
        ce    = 1'b0;
        flush = 1'b0;
        len   = l;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL sweep_len: busy cycles %0d, required 16", n);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy !== 1'b1 || dout !== 8'h00 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b dout=%h dvalid=%b, required 1/00/0", busy, dout, dvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ce    = 1'b1;
        din   = 8'h77;
        len   = 4'd3;
        for (int c = 1; c <= 17; c++) begin
            checks++;
            if (busy !== (c <= 16) || dout !== 8'h00 || dvalid !== 1'b0) begin
                errors++;
                $display("FAIL init_cycle%0d: busy=%b dout=%h dvalid=%b, required %b/00/0",
                         c, busy, dout, dvalid, (c <= 16));
            end
            if (c < 17) tick();
        end
        ce = 1'b0;
    endtask

    task automatic test_stream();
        do_reset(4'd3);
        ce = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic [7:0] exp_d;
            logic       exp_v;
            din = 8'(k);
            tick();
            exp_d = (k > 4) ? 8'(k - 4) : 8'h00;
            exp_v = (k > 4);
            checks++;
            if (dout !== exp_d || dvalid !== exp_v) begin
                errors++;
                $display("FAIL stream_step%0d: dout=%h dvalid=%b, required %h/%b", k, dout, dvalid, exp_d, exp_v);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_ce_gaps();
        logic [15:0] pat;
        logic [7:0]  exp_d;
        logic        exp_v;
        int          n;
        pat   = 16'b1111_0011_0101_1001;
        exp_d = 8'h00;
        exp_v = 1'b0;
        n     = 0;
        do_reset(4'd3);
        for (int i = 15; i >= 0; i--) begin
            ce = pat[i];
            if (pat[i]) begin
                n++;
                din = 8'(n + 16);
                exp_d = (n > 4) ? 8'(n - 4 + 16) : 8'h00;
                exp_v = (n > 4);
            end else begin
                din = 8'hEE;
            end
            tick();
            checks++;
            if (dout !== exp_d || dvalid !== exp_v) begin
                errors++;
                $display("FAIL ce_gap_cycle%0d: dout=%h dvalid=%b, required %h/%b", 15 - i, dout, dvalid, exp_d, exp_v);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_len0();
        logic [7:0] vin [3];
        logic [7:0] ed  [3];
        logic       ev  [3];
        vin = '{8'hA5, 8'h5A, 8'h3C};
        ed  = '{8'h00, 8'hA5, 8'h5A};
        ev  = '{1'b0, 1'b1, 1'b1};
        do_reset(4'd0);
        ce = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = vin[k];
            tick();
            checks++;
            if (dout !== ed[k] || dvalid !== ev[k]) begin
                errors++;
                $display("FAIL len0_step%0d: dout=%h dvalid=%b, required %h/%b", k + 1, dout, dvalid, ed[k], ev[k]);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_flush();
        int n;
        do_reset(4'd15);
        ce  = 1'b1;
        din = 8'hFF;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (dout !== 8'hFF || dvalid !== 1'b1) begin
            errors++;
            $display("FAIL prefill: dout=%h dvalid=%b, required ff/1", dout, dvalid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || dout !== 8'h00 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: busy=%b dout=%h dvalid=%b, required 1/00/0", busy, dout, dvalid);
        end
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16 || dout !== 8'h00 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_sweep: busy cycles %0d dout=%h dvalid=%b, required 16/00/0", n, dout, dvalid);
        end
        for (int k = 1; k <= 18; k++) begin
            logic [7:0] exp_d;
            logic       exp_v;
            din = 8'(k);
            tick();
            exp_d = (k > 16) ? 8'(k - 16) : 8'h00;
            exp_v = (k > 16);
            checks++;
            if (dout !== exp_d || dvalid !== exp_v) begin
                errors++;
                $display("FAIL post_flush_step%0d: dout=%h dvalid=%b, required %h/%b", k, dout, dvalid, exp_d, exp_v);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_len_change();
        do_reset(4'd3);
        ce = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [7:0] exp_d;
            din = 8'(k);
            tick();
            if (k == 1) len = 4'd7;
            if (k <= 4)       exp_d = 8'h00;
            else if (k <= 8)  exp_d = 8'(k - 4);
            else if (k <= 12) exp_d = 8'h00;
            else              exp_d = 8'(k - 8);
            checks++;
            if (dout !== exp_d) begin
                errors++;
                $display("FAIL len_change_step%0d: dout=%h, required %h", k, dout, exp_d);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        // Prior test leaves dout nonzero in RUN.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || busy !== 1'b1 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL arst_run: dout=%h busy=%b dvalid=%b, required 00/1/0", dout, busy, dvalid);
        end
        len = 4'd3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_sweep: dout=%h busy=%b, required 00/1", dout, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL arst_resweep: busy cycles %0d, required 16", n);
        end
        ce = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            din = 8'(k + 8'h40);
            tick();
        end
        ce = 1'b0;
        checks++;
        if (dout !== 8'h41 || dvalid !== 1'b1) begin
            errors++;
            $display("FAIL arst_resume: dout=%h dvalid=%b, required 41/1", dout, dvalid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ce_gaps();
        test_len0();
        test_flush();
        test_len_change();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
